// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and, later, the
// KeyboardDecoder receive path.
//   ps2_state_e  : transmitter FSM states
//   ST_*         : completion status codes reported with the done pulse
//   FRAME_EDGES  : device clock falls in one host-to-device frame
//   odd_parity() : parity bit that makes the 9-bit data+parity field odd
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        SHIFT     = 3'd3,
        WAIT_IDLE = 3'd4
    } ps2_state_e;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NACK    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam int FRAME_EDGES = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Conditions one raw PS/2 pad: 2-FF synchronizer, then a glitch filter that
// only accepts a new level after FILTER_CYCLES consecutive samples of it,
// plus a one-cycle strobe on every accepted 1->0 transition.
//   clk, rst : system clock, asynchronous active-high reset
//   line_in  : raw pad value (asynchronous to clk)
//   level    : filtered line level (idles high)
//   fall     : one-cycle pulse in the first cycle level reads 0
// ---------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic          sync0_q, sync0_d;
    logic          sync1_q, sync1_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall_q, fall_d;

    always_comb begin
        sync0_d = line_in;
        sync1_d = sync0_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        // cnt tracks how many samples in a row have disagreed with the
        // accepted level; any agreeing sample restarts the run.
        if (sync1_q != filt_q) begin
            if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                filt_d = sync1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    // Lines idle high, so every stage resets to 1 to avoid a phantom edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q <= 1'b1;
            sync1_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    assign level = filt_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Sends one command byte from the host to a PS/2 device. Both lines are
// open-drain: an *_oe of 1 pulls the line low, 0 releases it.
//   clk, rst     : system clock, asynchronous active-high reset
//   tx_valid/tx_data/tx_ready : byte handshake, accepted only when idle
//   ps2_clk_in, ps2_data_in   : raw pad values fed back from the lines
//   ps2_clk_oe, ps2_data_oe   : open-drain pull-down enables
//   busy   : transfer in progress (receive path ignores frames meanwhile)
//   done   : one-cycle pulse ending every accepted transfer
//   status : valid with done -- ST_OK, ST_NACK or ST_TIMEOUT
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic [1:0] status
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e    state_q, state_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [3:0]    n_q, n_d;
    logic [7:0]    byte_q, byte_d;
    logic          parity_q, parity_d;
    logic [1:0]    pend_q, pend_d;
    logic          tx_ready_q, tx_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [1:0]    status_q, status_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;

    logic clk_level, clk_fall;
    logic data_level, data_fall_unused;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clk    (clk),
        .rst    (rst),
        .line_in(ps2_clk_in),
        .level  (clk_level),
        .fall   (clk_fall)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
        .clk    (clk),
        .rst    (rst),
        .line_in(ps2_data_in),
        .level  (data_level),
        .fall   (data_fall_unused)
    );

    always_comb begin
        state_d   = state_q;
        inh_d     = inh_q;
        wdog_d    = wdog_q;
        n_d       = n_q;
        byte_d    = byte_q;
        parity_d  = parity_q;
        pend_d    = pend_q;
        status_d  = status_q;
        done_d    = 1'b0;
        data_oe_d = data_oe_q;

        unique case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    byte_d   = tx_data;
                    parity_d = odd_parity(tx_data);
                    inh_d    = '0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_d = inh_q + 1'b1;
                if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                    state_d = START;
                end
            end
            START: begin
                // Leaving START releases the clock with the start bit held.
                n_d     = '0;
                wdog_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                wdog_d = wdog_q + 1'b1;
                if (clk_fall) begin
                    n_d = (n_q == 4'hF) ? n_q : n_q + 4'd1;
                    // The device samples on the rising edge, so each bit is
                    // presented right after the preceding fall.
                    if (n_d <= 4'd8) begin
                        data_oe_d = ~byte_q[3'(n_d - 4'd1)];
                    end else if (n_d == 4'd9) begin
                        data_oe_d = ~parity_q;
                    end else if (n_d == 4'd10) begin
                        data_oe_d = 1'b0;
                    end else if (n_d == 4'(FRAME_EDGES)) begin
                        pend_d  = data_level ? ST_NACK : ST_OK;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                wdog_d = wdog_q + 1'b1;
                if (clk_level && data_level) begin
                    done_d   = 1'b1;
                    status_d = pend_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog overrides any frame progress made in the same cycle.
        if ((state_q == SHIFT || state_q == WAIT_IDLE) &&
            wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
            done_d   = 1'b1;
            status_d = ST_TIMEOUT;
            state_d  = IDLE;
        end

        clk_oe_d = (state_d == INHIBIT) || (state_d == START);
        if (state_d == START) begin
            data_oe_d = 1'b1;
        end else if (state_d != SHIFT) begin
            data_oe_d = 1'b0;
        end

        // Ready returns one cycle after done so a new request cannot
        // collide with the completion pulse.
        tx_ready_d = (state_d == IDLE) && !done_d;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inh_q      <= '0;
            wdog_q     <= '0;
            n_q        <= '0;
            pend_q     <= ST_OK;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= ST_OK;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inh_q      <= inh_d;
            wdog_q     <= wdog_d;
            n_q        <= n_d;
            pend_q     <= pend_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            status_q   <= status_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
        end
    end

    // Payload only; never observed before being loaded on acceptance.
    always_ff @(posedge clk) begin
        byte_q   <= byte_d;
        parity_q <= parity_d;
    end

    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign status      = status_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Drives ps2_host_tx against a behavioural PS/2 device. Inhibit and watchdog
// lengths are scaled down so every scenario fits a short run; the device
// clocks with a 2*HALF cycle period.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
    localparam int INHIBIT = 120;
    localparam int TIMEOUT = 3000;
    localparam int FILTER  = 8;
    localparam int HALF    = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done;
    logic [1:0] status;
    logic       ps2_clk_line, ps2_data_line;

    // Wired-AND of host pull-downs and device drive.
    assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FILTER_CYCLES (FILTER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .status     (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] bits;
        logic [1:0] status;
        bit         has_bits;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] dev_bits = '0;
    int         errors = 0;
    int         checks = 0;
    int         done_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Line bits the device should see after falls 1..10: data LSB first,
    // odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic p;
        p = (($countones(b) % 2) == 0);
        return {1'b1, p, b};
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            done_seen++;
            check_eq("exp_available", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("status", status, e.status);
                if (e.has_bits) check_eq("frame_bits", dev_bits, e.bits);
                check_eq("oe_at_done", {ps2_clk_oe, ps2_data_oe}, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] st, input bit has_bits);
        int w;
        exp_t e;
        w = 0;
        while (!tx_ready && w < 100) begin
            tick(1);
            w++;
        end
        check_eq("ready_before_send", tx_ready, 1);
        e.bits = frame_of(b);
        e.status = st;
        e.has_bits = has_bits;
        exp_q.push_back(e);
        tx_valid = 1'b1;
        tx_data  = b;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Device: waits for the host request, then clocks 11 falls. glitch_fall
    // injects a 3-cycle low pulse in the high phase before that fall;
    // stop_after returns early with the clock held low after that fall.
    task automatic run_device(input bit ack, input int glitch_fall, input int stop_after);
        int w;
        w = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < 1000) begin
            tick(1);
            w++;
        end
        check_eq("request_seen", 32'(w < 1000), 1);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) dev_data = 1'b0;
            if (k == glitch_fall) begin
                tick(HALF / 2);
                dev_clk = 1'b0;
                tick(3);
                dev_clk = 1'b1;
                tick(HALF - HALF / 2 - 3);
            end else begin
                tick(HALF);
            end
            dev_clk = 1'b0;
            if (k == stop_after) return;
            tick(HALF);
            if (k <= 10) dev_bits[k-1] = ps2_data_line;
            dev_clk = 1'b1;
        end
        tick(4);
        dev_data = 1'b1;
    endtask

    task automatic wait_done(input int bound);
        int w;
        w = 0;
        while (!done && w < bound) begin
            tick(1);
            w++;
        end
        check_eq("done_pulse", done, 1);
        tick(1);
        check_eq("ready_after_done", tx_ready, 1);
    endtask

    initial begin
        int n;
        int d;

        // Reset state
        tick(2);
        check_eq("reset_outputs",
                 {tx_ready, busy, done, status, ps2_clk_oe, ps2_data_oe}, 7'b1000000);
        rst = 1'b0;
        tick(2);

        // 1: 0xED with inhibit/start timing
        send(8'hED, 2'b00, 1);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < INHIBIT + 50) begin
            n++;
            tick(1);
        end
        check_eq("inhibit_cycles", n, INHIBIT);
        check_eq("start_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        tick(1);
        check_eq("release_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
        run_device(1, 0, 0);
        check_eq("ed_bits", dev_bits, 10'b11_1110_1101);
        wait_done(200);

        // 2: parity of 0x07 and 0x00
        send(8'h07, 2'b00, 1);
        run_device(1, 0, 0);
        check_eq("parity_07", dev_bits[8], 0);
        wait_done(200);
        send(8'h00, 2'b00, 1);
        run_device(1, 0, 0);
        check_eq("parity_00", dev_bits[8], 1);
        wait_done(200);

        // 3: no acknowledge
        send(8'h12, 2'b01, 1);
        run_device(0, 0, 0);
        wait_done(200);

        // 4: device never clocks
        send(8'hF0, 2'b10, 0);
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < INHIBIT + 50) begin
            tick(1);
            n++;
        end
        n = 0;
        while (!done && n < TIMEOUT + 100) begin
            tick(1);
            n++;
        end
        check_eq("timeout_cycles", n, TIMEOUT);
        tick(1);
        check_eq("ready_after_timeout", tx_ready, 1);

        // 5: reset mid-frame after fall 5 (0xA5 bit 4 is 0, so data is pulled)
        send(8'hA5, 2'b00, 1);
        run_device(1, 0, 5);
        tick(30);
        check_eq("data_oe_fall5", ps2_data_oe, 1);
        d = done_seen;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_oe_async", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check_eq("rst_ready", {tx_ready, busy}, 2'b10);
        exp_q.delete();
        dev_clk = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(100);
        check_eq("no_done_after_rst", done_seen, d);
        send(8'hFF, 2'b00, 1);
        run_device(1, 0, 0);
        wait_done(200);

        // 6: request while busy plus a clock glitch
        send(8'h3C, 2'b00, 1);
        fork
            run_device(1, 4, 0);
            begin
                int w;
                w = 0;
                while (!(busy && !ps2_clk_oe) && w < 1000) begin
                    tick(1);
                    w++;
                end
                tick(6 * HALF);
                check_eq("ready_in_shift", tx_ready, 0);
                tx_valid = 1'b1;
                tx_data  = 8'h55;
                tick(1);
                tx_valid = 1'b0;
            end
        join
        wait_done(200);
        tick(INHIBIT + 50);
        check_eq("busy_request_dropped", {busy, ps2_clk_oe}, 2'b00);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
